// File: rtl/clb_cfg_pkg.sv
// Shared types and constants for the CLB configuration loader: FSM states,
// default frame width and power-on config, and the cfg_out field map.
package clb_cfg_pkg;

    localparam int                     CFG_W_DEF     = 37;
    localparam logic [CFG_W_DEF-1:0]   CFG_RESET_DEF = 37'h15_0008_B038;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_PARITY,
        ST_COMMIT,
        ST_ERROR,
        ST_READBACK,
        ST_RB_LAST
    } state_e;

    // cfg_out field map, MSB to LSB
    localparam int MUX_SEL_W     = 2;
    localparam int MUX2_SEL_LSB  = 35;
    localparam int MUX3_SEL_LSB  = 33;
    localparam int MUX4_SEL_LSB  = 31;
    localparam int MUX5_SEL_LSB  = 29;
    localparam int MUX6_SEL_LSB  = 27;
    localparam int MEM_LSB       = 11;
    localparam int MEM_W         = 16;
    localparam int COMBOPT_LSB   = 9;
    localparam int COMBOPT_W     = 2;
    localparam int O2M_LSB       = 3;   // {1_0,2_0,3_0,1_1,2_1,3_1}
    localparam int O2M_W         = 6;
    localparam int DQMUX_LSB     = 1;   // {1,2}
    localparam int DQMUX_W       = 2;
    localparam int FLOPLATCH_BIT = 0;

endpackage

// File: rtl/clb_cfg_loader_if.sv
// Serial load / readback handshake between the config chain (master) and
// one clb_cfg_loader (slave).
interface clb_cfg_loader_if;

    logic start;
    logic din;
    logic din_valid;
    logic rb_start;
    logic busy;
    logic done;
    logic err;
    logic dout;
    logic dout_valid;

    modport master (
        output start, din, din_valid, rb_start,
        input  busy, done, err, dout, dout_valid
    );

    modport slave (
        input  start, din, din_valid, rb_start,
        output busy, done, err, dout, dout_valid
    );

endinterface

// File: rtl/clb_cfg_shreg.sv
// Shadow shift register with running parity of every bit shifted in;
// a parallel load seeds it (and the parity) from the live config for readback.
module clb_cfg_shreg #(
    parameter int W = 37
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic         shift,
    input  logic         din,
    input  logic [W-1:0] load_data,
    output logic [W-1:0] q,
    output logic         par
);

    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q   <= '0;
            par <= 1'b0;
        end else if (load) begin
            q   <= load_data;
            par <= ^load_data;
        end else if (shift) begin
            q   <= {q[W-2:0], din};
            par <= par ^ din;
        end
    end

endmodule

// File: rtl/clb_cfg_loader.sv
// Serial config loader for one CLB: framed bitstream + even parity into a shadow
// register, atomic commit to cfg_out. Readback built only with CLB_CFG_READBACK_EN.
module clb_cfg_loader
    import clb_cfg_pkg::*;
#(
    parameter int               CFG_W     = CFG_W_DEF,
    parameter logic [CFG_W-1:0] CFG_RESET = CFG_RESET_DEF
) (
    input  logic              K,
    input  logic              RST,
    clb_cfg_loader_if.slave   bus,
    output logic [CFG_W-1:0]  cfg_out
);

    localparam int               CNT_W    = $clog2(CFG_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CFG_W - 1);
    localparam logic [CNT_W-1:0] RB_BITS  = CNT_W'(CFG_W);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic             busy_q, done_q, err_q, dout_q, dout_valid_q;

    logic             sh_clr, sh_load, sh_shift, sh_din, sh_par, rb_go;
    logic [CFG_W-1:0] sh_q;

`ifdef CLB_CFG_READBACK_EN
    assign rb_go = (state == ST_IDLE) && bus.rb_start && !bus.start;
`else
    logic unused_rb;
    assign rb_go     = 1'b0;
    assign unused_rb = bus.rb_start;
`endif

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        sh_clr   = 1'b0;
        sh_load  = rb_go;
        sh_shift = 1'b0;
        sh_din   = 1'b0;
        case (state)
            ST_IDLE:     sh_clr   = bus.start;
            ST_SHIFT:    begin sh_shift = bus.din_valid; sh_din = bus.din; end
            ST_READBACK: sh_shift = (cnt != RB_BITS);
            default:     ;
        endcase
    end

    clb_cfg_shreg #(.W(CFG_W)) u_shreg (
        .clk       (K),
        .rst       (RST),
        .clr       (sh_clr),
        .load      (sh_load),
        .shift     (sh_shift),
        .din       (sh_din),
        .load_data (cfg_out),
        .q         (sh_q),
        .par       (sh_par)
    );

    always_ff @(posedge K) begin
        if (RST) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            cfg_out      <= CFG_RESET;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (bus.start) begin
                        state  <= ST_SHIFT;
                        busy_q <= 1'b1;
                    end else if (rb_go) begin
                        state  <= ST_READBACK;
                        busy_q <= 1'b1;
                    end
                end
                ST_SHIFT: if (bus.din_valid) begin
                    if (cnt == LAST_BIT) begin
                        state <= ST_PARITY;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_PARITY: if (bus.din_valid) begin
                    // Running parity covers the payload; adding p must give even.
                    if ((sh_par ^ bus.din) == 1'b0) begin
                        state   <= ST_COMMIT;
                        cfg_out <= sh_q;
                        done_q  <= 1'b1;
                    end else begin
                        state <= ST_ERROR;
                        err_q <= 1'b1;
                    end
                end
                ST_COMMIT, ST_ERROR: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                ST_READBACK: begin
                    dout_valid_q <= 1'b1;
                    if (cnt == RB_BITS) begin
                        dout_q <= sh_par;
                        state  <= ST_RB_LAST;
                    end else begin
                        dout_q <= sh_q[CFG_W-1];
                        cnt    <= cnt + 1'b1;
                    end
                end
                ST_RB_LAST: begin
                    dout_q       <= 1'b0;
                    dout_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Randomized bench for clb_cfg_loader: frames are scored against a model that
// keeps only the expected committed config; readback checked when CLB_CFG_READBACK_EN.
module tb_clb_cfg_loader;
    import clb_cfg_pkg::*;

    localparam int W = CFG_W_DEF;

    logic         K   = 1'b0;
    logic         RST = 1'b1;
    logic [W-1:0] cfg_out;
    logic [W-1:0] exp_cfg;
    int           n_checks = 0;
    int           n_errors = 0;

    clb_cfg_loader_if bus ();

    clb_cfg_loader dut (
        .K       (K),
        .RST     (RST),
        .bus     (bus),
        .cfg_out (cfg_out)
    );

    always #5 K = ~K;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge K);
        #1;
    endtask

    task automatic idle_inputs;
        bus.start     = 1'b0;
        bus.din       = 1'b0;
        bus.din_valid = 1'b0;
        bus.rb_start  = 1'b0;
    endtask

    task automatic do_reset(input int n);
        RST = 1'b1;
        idle_inputs();
        repeat (n) tick();
        RST     = 1'b0;
        exp_cfg = CFG_RESET_DEF;
        check("rst_status", {bus.busy, bus.done, bus.err, bus.dout, bus.dout_valid}, 5'b0);
        check("rst_cfg", cfg_out, exp_cfg);
    endtask

    // mode: 0 = din_valid continuous, 1 = valid every other cycle, 2 = random
    // abort_at >= 0: assert RST once that many payload bits have been taken
    task automatic run_frame(input logic [W-1:0] frame, input bit bad_par,
                             input int mode, input bit noise, input int abort_at);
        bit p    = (^frame) ^ bad_par;
        bit good = !bad_par;
        bit v, b;
        int idx  = 0;
        int cyc  = 0;

        bus.start     = 1'b1;
        bus.rb_start  = 1'($urandom_range(0, 1));
        bus.din_valid = 1'b0;
        tick();
        bus.start    = 1'b0;
        bus.rb_start = 1'b0;
        check("start_busy", {bus.busy, bus.dout_valid}, 2'b10);

        while (idx < W + 1 && !(abort_at >= 0 && idx >= abort_at) && cyc < 1000) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 1) : 1'($urandom_range(0, 1));
            b = (idx < W) ? frame[W-1-idx] : p;
            bus.din_valid = v;
            bus.din       = v ? b : 1'($urandom_range(0, 1));
            bus.start     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            cyc++;
            if (v) idx++;
            if (idx < W + 1) begin
                check("mid_status", {bus.busy, bus.done, bus.err}, 3'b100);
                check("mid_cfg", cfg_out, exp_cfg);
            end
        end
        bus.start     = 1'b0;
        bus.din_valid = 1'b0;

        if (abort_at >= 0 && idx >= abort_at) begin
            RST = 1'b1;
            tick();
            RST     = 1'b0;
            exp_cfg = CFG_RESET_DEF;
            check("abort_status", {bus.busy, bus.done, bus.err}, 3'b000);
            check("abort_cfg", cfg_out, exp_cfg);
            tick();
            check("abort_quiet", {bus.busy, bus.done, bus.err}, 3'b000);
            return;
        end

        check("frame_bits", idx, W + 1);
        check("end_status", {bus.busy, bus.done, bus.err}, {1'b1, good, !good});
        if (good) exp_cfg = frame;
        check("end_cfg", cfg_out, exp_cfg);
        check("end_mem", cfg_out[MEM_LSB +: MEM_W], exp_cfg[MEM_LSB +: MEM_W]);
        if (mode == 0) check("latency", cyc, W + 1);
        if (mode == 1) check("latency_stall", cyc, 2 * (W + 1));

        tick();
        check("post_status", {bus.busy, bus.done, bus.err}, 3'b000);
        check("post_cfg", cfg_out, exp_cfg);
    endtask

`ifdef CLB_CFG_READBACK_EN
    task automatic readback;
        logic [W:0] got = '0;
        int n   = 0;
        int cyc = 0;
        bus.rb_start = 1'b1;
        tick();
        bus.rb_start = 1'b0;
        check("rb_busy", bus.busy, 1'b1);
        while (bus.busy && cyc < 200) begin
            bus.start = 1'($urandom_range(0, 1));
            if (bus.dout_valid) begin
                got = {got[W-1:0], bus.dout};
                n++;
            end
            tick();
            cyc++;
            check("rb_cfg_frozen", cfg_out, exp_cfg);
        end
        bus.start = 1'b0;
        check("rb_count", n, W + 1);
        check("rb_data", got, {exp_cfg, ^exp_cfg});
        check("rb_end", {bus.busy, bus.dout_valid, bus.done, bus.err}, 4'b0);
    endtask
`else
    task automatic readback;
        bus.rb_start = 1'b1;
        repeat (3) begin
            tick();
            check("rb_ignored", {bus.busy, bus.dout, bus.dout_valid}, 3'b000);
        end
        bus.rb_start = 1'b0;
        check("rb_cfg_same", cfg_out, exp_cfg);
    endtask
`endif

    initial begin
        logic [W-1:0] frame;
        logic [63:0]  r;

        idle_inputs();
        do_reset(2);

        frame = 37'h00_0000_FFFF;
        run_frame(frame, 1'b0, 0, 1'b0, -1);
        readback();

        do_reset(2);
        run_frame(frame, 1'b1, 0, 1'b0, -1);
        check("bad_par_keeps_reset", cfg_out, CFG_RESET_DEF);

        run_frame(frame, 1'b0, 1, 1'b1, -1);

        r = {$urandom(), $urandom()};
        run_frame(r[W-1:0], 1'b0, 0, 1'b0, 21);
        r = {$urandom(), $urandom()};
        run_frame(r[W-1:0], 1'b0, 0, 1'b0, -1);
        readback();

        for (int i = 0; i < 20; i++) begin
            r = {$urandom(), $urandom()};
            run_frame(r[W-1:0], ($urandom_range(0, 3) == 0), 2, 1'b1, -1);
            if (i % 5 == 0) readback();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
